// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// instruction size and default boot address.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register that catches a returning read
// when the output register is stalled.
module fetch_skid_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    // Push wins over pop so a same-cycle pop/push keeps the new entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid     <= 1'b1;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC and the shared instruction-memory
// port (loader writes in IDLE, fetch reads otherwise) and feeds decode.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              busy,
    output fetch_state_t      state_dbg
);

    // Handshakes: a loader write transfers when load_valid & load_ready;
    // decode takes instr when instr_valid & !stall, otherwise instr is held.

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pend_pc;
    logic              pending;
    logic              issue;
    logic              load_fire;
    logic              redirect_take;
    logic              out_accept;
    logic              skid_valid;
    logic              skid_push;
    logic              skid_pop;
    logic [DATA_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    assign load_ready    = (state == ST_IDLE);
    assign load_fire     = load_valid && load_ready && !rst;
    assign redirect_take = redirect_valid && (state != ST_IDLE);
    assign issue = (state == ST_FETCH) && !stall && !skid_valid &&
                   !redirect_valid && !halt_req;

    assign mem_rd    = issue && !rst;
    assign mem_wr    = load_fire;
    assign mem_addr  = load_fire ? load_addr : (mem_rd ? pc : '0);
    assign mem_wdata = load_fire ? load_data : '0;

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // A returning read goes to the skid whenever the output register is
    // blocked, or when the skid's older entry is the one moving out.
    assign out_accept = !instr_valid || !stall;
    assign skid_pop   = !redirect_take && out_accept && skid_valid;
    assign skid_push  = !redirect_take && pending && (!out_accept || skid_valid);

    fetch_skid_buffer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (skid_push),
        .pop      (skid_pop),
        .flush    (redirect_take),
        .in_instr (mem_rdata),
        .in_pc    (pend_pc),
        .valid    (skid_valid),
        .out_instr(skid_instr),
        .out_pc   (skid_pc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: if (halt_req) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!pending && !skid_valid && out_accept) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            pending     <= 1'b0;
            pend_pc     <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state   <= state_nxt;
            pending <= issue;
            if (issue) pend_pc <= pc;

            if (redirect_take)
                pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            else if ((state == ST_IDLE) && start)
                pc <= RESET_PC;
            else if (issue)
                pc <= pc + ADDR_W'(INSTR_BYTES);

            if (redirect_take) begin
                instr_valid <= 1'b0;
            end else if (out_accept) begin
                if (skid_valid) begin
                    instr_valid <= 1'b1;
                    instr       <= skid_instr;
                    instr_pc    <= skid_pc;
                end else if (pending) begin
                    instr_valid <= 1'b1;
                    instr       <= mem_rdata;
                    instr_pc    <= pend_pc;
                end else begin
                    instr_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a small behavioural instruction
// memory (write on mem_wr, registered read data the cycle after mem_rd).
module tb_fetch_controller;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt_req;
    logic        load_valid;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        busy;
    fetch_state_t state_dbg;

    logic [31:0] mem [16];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .busy(busy), .state_dbg(state_dbg)
    );

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr[5:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here and
    // checks happen after a short settle delay.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [31:0] p);
        chk({tag, "_valid"}, 32'(instr_valid), 32'(v));
        if (v) begin
            chk({tag, "_instr"}, instr, d);
            chk({tag, "_pc"}, instr_pc, p);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; load_valid = 1'b0;
        load_addr = '0; load_data = '0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        settle();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lready", 32'(load_ready), 32'd1);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // Boot load; the last write coincides with start.
        for (int i = 0; i < 4; i++) begin
            tick();
            load_valid = 1'b1;
            load_addr  = 32'(i * 4);
            load_data  = 32'(8'h11 * (i + 1));
            start      = (i == 3);
            settle();
            chk("ld_wr", 32'(mem_wr), 32'd1);
            chk("ld_addr", mem_addr, 32'(i * 4));
            chk("ld_wdata", mem_wdata, 32'(8'h11 * (i + 1)));
            chk("ld_rd", 32'(mem_rd), 32'd0);
        end
        tick(); load_valid = 1'b0; start = 1'b0; settle();
        chk("f1_rd", 32'(mem_rd), 32'd1);
        chk("f1_addr", mem_addr, 32'h0);
        chk("f1_busy", 32'(busy), 32'd1);
        chk("f1_lready", 32'(load_ready), 32'd0);
        chk_out("f1", 1'b0, 32'h0, 32'h0);
        load_valid = 1'b1; load_addr = 32'h30; load_data = 32'hDEAD; settle();
        chk("ld_outside_idle", 32'(mem_wr), 32'd0);
        tick(); load_valid = 1'b0; settle();
        chk("f2_addr", mem_addr, 32'h4);
        chk_out("f2", 1'b0, 32'h0, 32'h0);
        tick(); settle();
        chk_out("f3", 1'b1, 32'h11, 32'h0);
        chk("f3_addr", mem_addr, 32'h8);

        // Stall three cycles holding 0x22 while 0x33 returns into the skid.
        tick(); stall = 1'b1; settle();
        chk_out("s0", 1'b1, 32'h22, 32'h4);
        chk("s0_rd", 32'(mem_rd), 32'd0);
        tick(); settle();
        chk_out("s1", 1'b1, 32'h22, 32'h4);
        chk("s1_rd", 32'(mem_rd), 32'd0);
        tick(); settle();
        chk_out("s2", 1'b1, 32'h22, 32'h4);
        tick(); stall = 1'b0; settle();
        chk_out("s3", 1'b1, 32'h22, 32'h4);
        chk("s3_rd", 32'(mem_rd), 32'd0);
        tick(); settle();
        chk_out("s4", 1'b1, 32'h33, 32'h8);
        chk("s4_rd", 32'(mem_rd), 32'd1);
        chk("s4_addr", mem_addr, 32'hC);
        tick(); settle();
        chk_out("s5", 1'b0, 32'h0, 32'h0);
        chk("s5_addr", mem_addr, 32'h10);
        tick(); settle();
        chk_out("s6", 1'b1, 32'h44, 32'hC);

        // Redirect to an unaligned target while stalled.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h9; settle();
        chk("rd_rd", 32'(mem_rd), 32'd0);
        tick(); stall = 1'b0; redirect_valid = 1'b0; settle();
        chk_out("rd1", 1'b0, 32'h0, 32'h0);
        chk("rd1_rd", 32'(mem_rd), 32'd1);
        chk("rd1_addr", mem_addr, 32'h8);
        tick(); settle();
        chk_out("rd2", 1'b0, 32'h0, 32'h0);
        chk("rd2_addr", mem_addr, 32'hC);
        tick(); settle();
        chk_out("rd3", 1'b1, 32'h33, 32'h8);

        // Halt: no further reads, the in-flight word still arrives.
        halt_req = 1'b1; settle();
        chk("h0_rd", 32'(mem_rd), 32'd0);
        tick(); halt_req = 1'b0; settle();
        chk_out("h1", 1'b1, 32'h44, 32'hC);
        chk("h1_rd", 32'(mem_rd), 32'd0);
        chk("h1_state", 32'(state_dbg), 32'(ST_DRAIN));
        start = 1'b1; settle();
        chk("h1_start_ignored", 32'(mem_rd), 32'd0);
        tick(); start = 1'b0; settle();
        chk("h2_busy", 32'(busy), 32'd0);
        chk("h2_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("h2_lready", 32'(load_ready), 32'd1);
        chk_out("h2", 1'b0, 32'h0, 32'h0);

        // Wrap-around fetch from the top of the address space.
        load_valid = 1'b1; load_addr = 32'hFFFF_FFFC; load_data = 32'hAA; settle();
        chk("w_ld_addr", mem_addr, 32'hFFFF_FFFC);
        tick(); load_valid = 1'b0; start = 1'b1;
        tick(); start = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
        chk("w1_rd", 32'(mem_rd), 32'd0);
        tick(); redirect_valid = 1'b0; settle();
        chk("w2_rd", 32'(mem_rd), 32'd1);
        chk("w2_addr", mem_addr, 32'hFFFF_FFFC);
        tick(); settle();
        chk("w3_addr", mem_addr, 32'h0);
        tick(); stall = 1'b1; settle();
        chk_out("w4", 1'b1, 32'hAA, 32'hFFFF_FFFC);

        // Reset mid-stream under stall, then restart from address 0.
        tick(); rst = 1'b1; settle();
        chk_out("r0", 1'b1, 32'hAA, 32'hFFFF_FFFC);
        tick(); rst = 1'b0; settle();
        chk_out("r1", 1'b0, 32'h0, 32'h0);
        chk("r1_instr", instr, 32'h0);
        chk("r1_rd", 32'(mem_rd), 32'd0);
        chk("r1_state", 32'(state_dbg), 32'(ST_IDLE));
        stall = 1'b0; start = 1'b1;
        tick(); start = 1'b0; settle();
        chk("r2_rd", 32'(mem_rd), 32'd1);
        chk("r2_addr", mem_addr, 32'h0);
        tick(); settle();
        chk("r3_addr", mem_addr, 32'h4);
        tick(); halt_req = 1'b1; settle();
        chk_out("r4", 1'b1, 32'h11, 32'h0);
        tick(); halt_req = 1'b0; settle();
        chk_out("r5", 1'b1, 32'h22, 32'h4);
        tick(); settle();
        chk("r6_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the instruction-fetch datapath.
- Owns the program counter and the single read/write port of the instruction memory.
- Shares that memory port between the boot program loader (writes, IDLE only) and the fetch stream (reads).
- Delivers a valid/stall-qualified instruction stream to decode, with branch redirect and halt/drain control.

Parameters:
- ADDR_W, 32, PC and memory address width (byte address).
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded when start is accepted.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin fetching from RESET_PC; honoured in IDLE only.
- halt_req  in  1  stop issuing reads, drain, return to IDLE.
- load_valid  in  1  loader write request.
- load_addr  in  ADDR_W  loader byte address.
- load_data  in  DATA_W  loader write data.
- load_ready  out  1  high in IDLE; write accepted when load_valid & load_ready.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd.
- stall  in  1  decode holds the current instruction.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  ADDR_W  redirect target.
- instr_valid  out  1  instr/instr_pc valid.
- instr  out  DATA_W  fetched instruction.
- instr_pc  out  ADDR_W  address of instr.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, pending=0, skid empty, instr_valid=0, instr=0, instr_pc=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts all in-flight reads and loader writes.
- States:
  - IDLE: start -> FETCH, pc<=RESET_PC.
  - FETCH: halt_req -> DRAIN.
  - DRAIN: pending=0 and skid empty and (instr_valid=0 or stall=0) -> IDLE.
- Loader (IDLE only): load_ready=1; on load_valid, mem_wr=1, mem_addr=load_addr, mem_wdata=load_data, combinationally in the same cycle.
- start together with load_valid: the write commits that cycle and start is also accepted; the first read issues the next cycle.
- Issue rule: issue = FETCH & !stall & !skid_valid & !redirect_valid & !halt_req.
  - On issue: mem_rd=1, mem_addr=pc, pc<=pc+4 (mod 2^ADDR_W), pending<=1, pend_pc<=pc.
- Return (cycle after issue, pending=1):
  - Output register accepts when instr_valid=0 or stall=0: it loads skid contents if skid is full, else mem_rdata/pend_pc.
  - If the output register cannot accept, mem_rdata/pend_pc go into the one-entry skid.
  - Nothing is dropped under stall.
- Consumption: instr_valid & !stall with nothing new to load -> instr_valid<=0. Under stall, instr and instr_pc are held.
- Latency: read issued in cycle t -> instr_valid in cycle t+2; steady-state throughput is one instruction per cycle.
- redirect_valid (any state except IDLE; highest priority over stall and halt):
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - pending discarded, skid cleared, instr_valid<=0.
  - First redirected read issues the following cycle.
- halt_req in FETCH: no further issue; in-flight data is still delivered.
- start outside IDLE: ignored. load_valid outside IDLE: not accepted.

Decomposition:
- Shared package fetch_pkg:
  - State encoding IDLE/FETCH/DRAIN.
  - INSTR_BYTES=4.
  - Default RESET_PC.
- One natural sub-module: fetch_skid_buffer, a one-entry {instr, pc} holding register with push/pop/flush and valid flag.

Test Plan:
- Load 4 words 0x11,0x22,0x33,0x44 at addresses 0,4,8,12, then start -> mem_wr pulses with those addresses; instr stream 0x11@0, 0x22@4, 0x33@8, 0x44@12 on consecutive cycles, first valid 2 cycles after start-accept+1.
- Stall high for 3 cycles while holding 0x22 with a read in flight -> instr stays 0x22@4, 0x33 is captured in skid; after release the stream continues 0x33@8, 0x44@12 with no loss or duplicates.
- redirect_valid with redirect_pc=0x00000009 while stalled -> next cycle instr_valid=0, the next read has mem_addr=0x08, and the first delivered instr_pc=0x08.
- halt_req during fetch -> no mem_rd after that cycle, remaining in-flight instruction delivered, busy falls, state IDLE, load_ready=1.
- pc near wrap: redirect_pc=0xFFFFFFFC -> reads at 0xFFFFFFFC then 0x00000000.
- rst asserted mid-stream with stall=1 -> next cycle instr_valid=0, mem_rd=0, state IDLE, pc=RESET_PC; start afterwards fetches from 0.
